// File: rtl/acc_result_fifo_if.sv
// Bus bundle between the accumulator result stream, the result FIFO and its consumer.
// The slave side is the FIFO; the master side is whatever drives the input stream
// and consumes the framed output.
interface acc_result_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic             last_o;
   logic [CW-1:0]    count_o;
   logic             full_o;
   logic             empty_o;
   logic             overflow_o;
   logic             clr_ovf_i;

   modport master (
      output data_in, valid_in, ready_i, clr_ovf_i,
      input  data_o, valid_o, last_o, count_o, full_o, empty_o, overflow_o
   );

   modport slave (
      input  data_in, valid_in, ready_i, clr_ovf_i,
      output data_o, valid_o, last_o, count_o, full_o, empty_o, overflow_o
   );
endinterface

// File: rtl/acc_result_fifo.sv
// Result buffer behind the stream accumulator: first-word-fall-through FIFO fed by a
// valid-only stream, ready/valid output framed into fixed-length packets, and a
// sticky overflow flag for words lost while the buffer was full.
// Every output is decoded from registered state only; no input reaches an output
// combinationally.
module acc_result_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int PACKET_LEN = 8
) (
   input logic              clk,
   input logic              rst,
   acc_result_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(PACKET_LEN - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [BW-1:0]    beat_cnt_r;
   logic             overflow_r;

   logic             valid_s;
   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic [CW-1:0]    count_nxt_s;
   logic [BW-1:0]    beat_nxt_s;
   logic             overflow_nxt_s;

   assign valid_s = (count_r != {CW{1'b0}});
   assign full_s  = (count_r == FULL_COUNT);
   assign pop_s   = valid_s && bus.ready_i;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign push_s  = bus.valid_in && (!full_s || pop_s);
   assign drop_s  = bus.valid_in && full_s && !pop_s;

   // Occupancy next-state: push and pop together leave the count unchanged.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Packet position next-state: advances on output pops only, wraps at packet end.
   always_comb begin
      beat_nxt_s = beat_cnt_r;
      if (pop_s) begin
         if (beat_cnt_r == LAST_BEAT) begin
            beat_nxt_s = {BW{1'b0}};
         end else begin
            beat_nxt_s = beat_cnt_r + BW'(1);
         end
      end else begin
         beat_nxt_s = beat_cnt_r;
      end
   end

   // Sticky overflow next-state: a drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_nxt_s = overflow_r;
      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else if (bus.clr_ovf_i) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

   // Control state: pointers, occupancy, packet position and overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         beat_cnt_r <= {BW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r    <= count_nxt_s;
         beat_cnt_r <= beat_nxt_s;
         overflow_r <= overflow_nxt_s;
      end
   end

   // Storage array: written on accepted pushes only, contents need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.data_in;
      end
   end

   // Head word is forced to zero while empty so stale storage never leaks out.
   assign bus.data_o     = valid_s ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
   assign bus.valid_o    = valid_s;
   assign bus.last_o     = valid_s && (beat_cnt_r == LAST_BEAT);
   assign bus.count_o    = count_r;
   assign bus.full_o     = full_s;
   assign bus.empty_o    = !valid_s;
   assign bus.overflow_o = overflow_r;
endmodule

// File: tb/tb_acc_result_fifo.sv
// Directed bench for acc_result_fifo: a vector table for the basic handshake plus
// hand-written sequences for fill/overflow, full-with-pop, framing under stalls,
// overflow-clear race and asynchronous reset mid-stream.
module tb_acc_result_fifo;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   acc_result_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

   acc_result_fifo #(.WIDTH(8), .DEPTH(16), .PACKET_LEN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       vin;
      logic [7:0] din;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [7:0] ed;
      logic [4:0] ec;
      logic       el;
      logic       ef;
      logic       ee;
      logic       eo;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.valid_in  = 1'b0;
      bus.data_in   = 8'h00;
      bus.ready_i   = 1'b0;
      bus.clr_ovf_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // Push n consecutive words base, base+1, ... with the consumer stalled.
   task automatic push_seq(input int n, input int base);
      bus.ready_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = 8'(base + i);
         step();
      end
      bus.valid_in = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      idle_inputs();

      //            vin   din    rdy   clr   ev    ed     ec     el    ef    ee    eo
      vecs[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};

      // Reset state
      step();
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_last", bus.last_o, 0);
      chk("rst_empty", bus.empty_o, 1);
      chk("rst_full", bus.full_o, 0);
      chk("rst_count", bus.count_o, 0);
      chk("rst_ovf", bus.overflow_o, 0);
      chk("rst_data", bus.data_o, 0);
      rst = 1'b1;

      // Table: single word and simple push/pop overlap
      for (int v = 0; v < 7; v++) begin
         bus.valid_in  = vecs[v].vin;
         bus.data_in   = vecs[v].din;
         bus.ready_i   = vecs[v].rdy;
         bus.clr_ovf_i = vecs[v].clr;
         step();
         chk($sformatf("vec%0d_valid", v), bus.valid_o, vecs[v].ev);
         chk($sformatf("vec%0d_count", v), bus.count_o, vecs[v].ec);
         chk($sformatf("vec%0d_last", v), bus.last_o, vecs[v].el);
         chk($sformatf("vec%0d_full", v), bus.full_o, vecs[v].ef);
         chk($sformatf("vec%0d_empty", v), bus.empty_o, vecs[v].ee);
         chk($sformatf("vec%0d_ovf", v), bus.overflow_o, vecs[v].eo);
         if (vecs[v].ev) begin
            chk($sformatf("vec%0d_data", v), bus.data_o, vecs[v].ed);
         end
      end

      // Fill and overflow: 18 pushes into 16 entries, then drain in order
      do_reset();
      bus.ready_i = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         bus.valid_in = 1'b1;
         bus.data_in  = 8'(i);
         step();
         if (i == 15) chk("fill15_full", bus.full_o, 0);
         if (i == 16) begin
            chk("fill16_full", bus.full_o, 1);
            chk("fill16_count", bus.count_o, 16);
            chk("fill16_ovf", bus.overflow_o, 0);
         end
         if (i == 17) begin
            chk("fill17_ovf", bus.overflow_o, 1);
            chk("fill17_count", bus.count_o, 16);
         end
      end
      bus.valid_in = 1'b0;
      bus.ready_i  = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         chk($sformatf("drain%0d_data", j), bus.data_o, j);
         chk($sformatf("drain%0d_last", j), bus.last_o, (j == 8 || j == 16) ? 1 : 0);
         step();
      end
      chk("drain_empty", bus.empty_o, 1);
      chk("drain_count", bus.count_o, 0);
      chk("drain_ovf_sticky", bus.overflow_o, 1);

      // Full with simultaneous pop: push accepted, no overflow
      do_reset();
      push_seq(16, 1);
      bus.valid_in = 1'b1;
      bus.data_in  = 8'hAA;
      bus.ready_i  = 1'b1;
      step();
      bus.valid_in = 1'b0;
      chk("fullpop_count", bus.count_o, 16);
      chk("fullpop_full", bus.full_o, 1);
      chk("fullpop_ovf", bus.overflow_o, 0);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("fullpop_drain%0d", k), bus.data_o, (k < 15) ? k + 2 : 8'hAA);
         step();
      end
      chk("fullpop_empty", bus.empty_o, 1);

      // Framing with ready toggling every cycle
      do_reset();
      begin
         int         exp_word;
         logic       pop_now;
         logic       held_v;
         logic       held_l;
         logic [7:0] held_d;
         exp_word = 1;
         for (int c = 0; c < 60; c++) begin
            bus.valid_in = (c < 20);
            bus.data_in  = 8'(c + 1);
            bus.ready_i  = (c % 2 == 0);
            if (bus.valid_o) begin
               chk($sformatf("frame_c%0d_data", c), bus.data_o, exp_word);
               chk($sformatf("frame_c%0d_last", c), bus.last_o,
                   (exp_word == 8 || exp_word == 16) ? 1 : 0);
            end
            pop_now = bus.valid_o && bus.ready_i;
            held_v  = bus.valid_o;
            held_l  = bus.last_o;
            held_d  = bus.data_o;
            step();
            if (pop_now) begin
               exp_word++;
            end else if (held_v) begin
               chk($sformatf("stall_c%0d_valid", c), bus.valid_o, 1);
               chk($sformatf("stall_c%0d_data", c), bus.data_o, held_d);
               chk($sformatf("stall_c%0d_last", c), bus.last_o, held_l);
            end
         end
         chk("frame_words_out", exp_word, 21);
         chk("frame_empty", bus.empty_o, 1);
      end

      // Overflow clear and clear-versus-drop race
      do_reset();
      push_seq(17, 1);
      chk("race_ovf_set", bus.overflow_o, 1);
      bus.clr_ovf_i = 1'b1;
      step();
      chk("race_clear", bus.overflow_o, 0);
      bus.valid_in = 1'b1;
      bus.data_in  = 8'h77;
      step();
      bus.valid_in  = 1'b0;
      bus.clr_ovf_i = 1'b0;
      chk("race_set_wins", bus.overflow_o, 1);
      chk("race_count", bus.count_o, 16);
      chk("race_head", bus.data_o, 1);

      // Asynchronous reset mid-stream (count 5, packet position 3, overflow set)
      do_reset();
      push_seq(17, 1);
      bus.ready_i = 1'b1;
      for (int i = 0; i < 11; i++) step();
      bus.ready_i = 1'b0;
      chk("pre_rst_count", bus.count_o, 5);
      chk("pre_rst_ovf", bus.overflow_o, 1);
      chk("pre_rst_head", bus.data_o, 12);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", bus.valid_o, 0);
      chk("arst_count", bus.count_o, 0);
      chk("arst_ovf", bus.overflow_o, 0);
      chk("arst_empty", bus.empty_o, 1);
      chk("arst_data", bus.data_o, 0);
      #1 rst = 1'b1;
      push_seq(8, 8'h40);
      bus.ready_i = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         chk($sformatf("post_rst%0d_data", j), bus.data_o, 8'h3F + j);
         chk($sformatf("post_rst%0d_last", j), bus.last_o, (j == 8) ? 1 : 0);
         step();
      end
      chk("post_rst_empty", bus.empty_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
